// File: rtl/frog_pkg.sv
// Shared types and defaults for the frog sprite controller.
package frog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOP   = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Direction codes double as priority order (lowest code wins).
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_DIRS     = 4;
    localparam int COORD_W      = 12;
    localparam int DEF_D_WIDTH  = 640;
    localparam int DEF_D_HEIGHT = 480;

endpackage

// File: rtl/frog_btn_arm.sv
// Per-direction arm latch: a button must be seen released before it can start a hop.
module frog_btn_arm (
    input  logic i_clk,
    input  logic i_rst,
    input  logic tick,
    input  logic btn_n,
    input  logic take,
    output logic armed
);

    // Arm on a released sample, disarm when the direction is consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            armed <= 1'b0;
        else if (tick) begin
            if (take)
                armed <= 1'b0;
            else if (btn_n)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/frog_hopper.sv
// Player sprite controller: grid hops, bounds clamping, lives, respawn blink, goal scoring.
module frog_hopper
    import frog_pkg::*;
#(
    parameter int H_WIDTH        = 11,
    parameter int H_HEIGHT       = 11,
    parameter int IX             = 320,
    parameter int IY             = 460,
    parameter int D_WIDTH        = DEF_D_WIDTH,
    parameter int D_HEIGHT       = DEF_D_HEIGHT,
    parameter int STEP           = 20,
    parameter int HOP_FRAMES     = 4,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int GOAL_Y         = 40
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_up_n,
    input  logic        i_down_n,
    input  logic        i_left_n,
    input  logic        i_right_n,
    input  logic        i_dead,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic        o_visible,
    output logic        o_busy,
    output logic [3:0]  o_lives,
    output logic [7:0]  o_score,
    output logic        o_goal,
    output logic        o_game_over
);

    localparam logic [11:0] HW      = 12'(H_WIDTH);
    localparam logic [11:0] HH      = 12'(H_HEIGHT);
    localparam logic [11:0] DELTA   = 12'(STEP / HOP_FRAMES);
    localparam logic [11:0] UP_MIN  = 12'(H_HEIGHT + STEP);
    localparam logic [11:0] DN_MAX  = 12'(D_HEIGHT - 1 - STEP - H_HEIGHT);
    localparam logic [11:0] LT_MIN  = 12'(H_WIDTH + STEP);
    localparam logic [11:0] RT_MAX  = 12'(D_WIDTH - 1 - STEP - H_WIDTH);
    localparam logic [11:0] GOAL_YC = 12'(GOAL_Y);
    localparam logic [11:0] SPAWN_X = 12'(IX);
    localparam logic [11:0] SPAWN_Y = 12'(IY);

    state_t      state;
    dir_t        dir;
    logic [11:0] x, y, nx, ny;
    logic [3:0]  cnt, lives;
    logic [7:0]  rcnt, rcnt_n, score;
    logic        vis, goal, dead_l, dead_eff, tick;

    logic [NUM_DIRS-1:0] btn_n, armed, ready, sel_oh, take;
    logic                sel_valid, on_screen, start;
    dir_t                sel_dir;

    assign tick     = i_ani_stb & i_animate;
    assign dead_eff = dead_l | i_dead;
    assign btn_n    = {i_right_n, i_left_n, i_down_n, i_up_n};
    assign ready    = ~btn_n & armed;
    assign rcnt_n   = rcnt + 8'd1;

    // Any consideration of a direction in IDLE consumes it, hop or not.
    assign start = tick && (state == ST_IDLE) && !dead_eff && sel_valid;
    assign take  = {NUM_DIRS{start}} & sel_oh;

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_arm
        frog_btn_arm u_arm (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .tick  (tick),
            .btn_n (btn_n[g]),
            .take  (take[g]),
            .armed (armed[g])
        );
    end

    // Priority pick up > down > left > right, plus the bounds check for the pick.
    always_comb begin
        sel_valid = 1'b1;
        sel_oh    = '0;
        sel_dir   = DIR_UP;
        on_screen = 1'b0;
        if (ready[0])      begin sel_oh = 4'b0001; sel_dir = DIR_UP;    on_screen = (y >= UP_MIN); end
        else if (ready[1]) begin sel_oh = 4'b0010; sel_dir = DIR_DOWN;  on_screen = (y <= DN_MAX); end
        else if (ready[2]) begin sel_oh = 4'b0100; sel_dir = DIR_LEFT;  on_screen = (x >= LT_MIN); end
        else if (ready[3]) begin sel_oh = 4'b1000; sel_dir = DIR_RIGHT; on_screen = (x <= RT_MAX); end
        else sel_valid = 1'b0;
    end

    // One hop increment along the latched direction.
    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = y - DELTA;
            DIR_DOWN:  ny = y + DELTA;
            DIR_LEFT:  nx = x - DELTA;
            DIR_RIGHT: nx = x + DELTA;
        endcase
    end

    // Collision latch: holds a pulse until the next frame; deaf while dying or over.
    always_ff @(posedge i_clk) begin
        if (i_rst || state == ST_DYING || state == ST_OVER || tick)
            dead_l <= 1'b0;
        else if (i_dead)
            dead_l <= 1'b1;
    end

    // Main controller.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            dir   <= DIR_UP;
            x     <= SPAWN_X;
            y     <= SPAWN_Y;
            cnt   <= '0;
            rcnt  <= '0;
            lives <= 4'(LIVES);
            score <= '0;
            vis   <= 1'b1;
            goal  <= 1'b0;
        end else begin
            goal <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE, ST_HOP: begin
                        if (dead_eff) begin
                            state <= ST_DYING;
                            lives <= (lives != 4'd0) ? lives - 4'd1 : 4'd0;
                            rcnt  <= '0;
                            vis   <= 1'b1;
                        end else if (state == ST_IDLE) begin
                            if (sel_valid && on_screen) begin
                                state <= ST_HOP;
                                dir   <= sel_dir;
                                cnt   <= '0;
                            end
                        end else if (cnt + 4'd1 == 4'(HOP_FRAMES)) begin
                            state <= ST_IDLE;
                            if (ny - HH <= GOAL_YC) begin
                                score <= (score != 8'hFF) ? score + 8'd1 : score;
                                goal  <= 1'b1;
                                x     <= SPAWN_X;
                                y     <= SPAWN_Y;
                            end else begin
                                x <= nx;
                                y <= ny;
                            end
                        end else begin
                            x   <= nx;
                            y   <= ny;
                            cnt <= cnt + 4'd1;
                        end
                    end
                    ST_DYING: begin
                        if (rcnt_n == 8'(RESPAWN_FRAMES)) begin
                            vis <= 1'b1;
                            if (lives == 4'd0)
                                state <= ST_OVER;
                            else begin
                                state <= ST_IDLE;
                                x     <= SPAWN_X;
                                y     <= SPAWN_Y;
                            end
                        end else begin
                            rcnt <= rcnt_n;
                            vis  <= ~rcnt_n[2];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_x1        = x - HW;
    assign o_x2        = x + HW;
    assign o_y1        = y - HH;
    assign o_y2        = y + HH;
    assign o_visible   = vis;
    assign o_busy      = (state == ST_HOP);
    assign o_lives     = lives;
    assign o_score     = score;
    assign o_goal      = goal;
    assign o_game_over = (state == ST_OVER);

endmodule
